busy_ckpt_ctrl: RTL

//  Branch checkpoint controller for busy_bit_table. Snapshots the busy list when a branch is renamed,

---
 rtl/busy_ckpt_ctrl_pkg.sv | 24 ++
 rtl/busy_ckpt_ctrl_if.sv | 29 ++
 rtl/busy_ckpt_ctrl_slot.sv | 32 +++
 rtl/busy_ckpt_ctrl.sv | 75 +++++++
 4 files changed

// File: rtl/busy_ckpt_ctrl_pkg.sv
// rtl/busy_ckpt_ctrl_pkg.sv - shared types, sizes and done-mask helper for the branch checkpoint controller
package busy_ckpt_ctrl_pkg;
    localparam int NUM_CKPT  = 4;
    localparam int NUM_PREGS = 64;
    localparam int NUM_DONE  = 2;
    localparam int TAG_W     = $clog2(NUM_CKPT);
    localparam int PREG_W    = $clog2(NUM_PREGS);

    typedef logic [TAG_W-1:0]     ckpt_tag_t;
    typedef logic [TAG_W:0]       ckpt_ptr_t;
    typedef logic [PREG_W-1:0]    preg_t;
    typedef logic [NUM_PREGS-1:0] busy_vec_t;

    // One bit per preg written back this cycle, across all writeback ports.
    function automatic busy_vec_t done_mask(input logic [NUM_DONE-1:0] done,
                                            input preg_t [NUM_DONE-1:0] addr);
        busy_vec_t m;
        m = '0;
        for (int j = 0; j < NUM_DONE; j++) begin
            if (done[j]) m[addr[j]] = 1'b1;
        end
        return m;
    endfunction
endpackage

// File: rtl/busy_ckpt_ctrl_if.sv
// rtl/busy_ckpt_ctrl_if.sv - rename/writeback/branch-unit/busy-table signals of the checkpoint controller
interface busy_ckpt_ctrl_if;
    import busy_ckpt_ctrl_pkg::*;

    logic                           alloc_req;
    busy_vec_t                      live_busy;
    logic                           alloc_ok;
    ckpt_tag_t                      alloc_tag;
    logic [NUM_DONE-1:0]            done;
    preg_t [NUM_DONE-1:0]           done_addr;
    logic                           resolve_valid;
    ckpt_tag_t                      resolve_tag;
    logic                           resolve_mispred;
    logic                           if_recall;
    busy_vec_t                      recalled_list;
    ckpt_ptr_t                      ckpt_count;

    modport slave (
        input  alloc_req, live_busy, done, done_addr,
        input  resolve_valid, resolve_tag, resolve_mispred,
        output alloc_ok, alloc_tag, if_recall, recalled_list, ckpt_count
    );

    modport master (
        output alloc_req, live_busy, done, done_addr,
        output resolve_valid, resolve_tag, resolve_mispred,
        input  alloc_ok, alloc_tag, if_recall, recalled_list, ckpt_count
    );
endinterface

// File: rtl/busy_ckpt_ctrl_slot.sv
// rtl/busy_ckpt_ctrl_slot.sv - one busy-list snapshot with write, writeback clear and valid bit
module busy_ckpt_slot
    import busy_ckpt_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_wr,
    input  busy_vec_t i_wdata,
    input  logic      i_clr,
    input  busy_vec_t i_dmask,
    output busy_vec_t o_snap,
    output logic      o_vld
);
    busy_vec_t r_snap;
    logic      r_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap <= '0;
            r_vld  <= 1'b0;
        end else begin
            // Invalid slots are cleared too; their contents are dead until rewritten.
            if (i_wr) r_snap <= i_wdata;
            else      r_snap <= r_snap & ~i_dmask;
            if (i_clr)     r_vld <= 1'b0;
            else if (i_wr) r_vld <= 1'b1;
        end
    end

    assign o_snap = r_snap;
    assign o_vld  = r_vld;
endmodule

// File: rtl/busy_ckpt_ctrl.sv
// rtl/busy_ckpt_ctrl.sv - branch checkpoint ring for busy_bit_table: snapshot on alloc, recall on mispredict
module busy_ckpt_ctrl
    import busy_ckpt_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    busy_ckpt_ctrl_if.slave ckpt
);
    ckpt_ptr_t r_head, r_tail;
    logic      r_recall;
    busy_vec_t r_rsnap;

    busy_vec_t            w_dmask;
    busy_vec_t            w_snap [NUM_CKPT];
    logic [NUM_CKPT-1:0]  w_vld;
    logic [NUM_CKPT-1:0]  w_clr;
    ckpt_ptr_t            w_count;
    ckpt_tag_t            w_head_idx, w_tail_idx, w_off_t;
    logic                 w_tag_vld, w_mis, w_cor, w_alloc, w_alloc_ok, w_retire;

    assign w_dmask    = done_mask(ckpt.done, ckpt.done_addr);
    assign w_head_idx = r_head[TAG_W-1:0];
    assign w_tail_idx = r_tail[TAG_W-1:0];
    assign w_count    = r_tail - r_head;
    assign w_alloc_ok = (w_count != ckpt_ptr_t'(NUM_CKPT)) & ~r_recall;

    assign w_tag_vld = w_vld[ckpt.resolve_tag];
    assign w_mis     = ckpt.resolve_valid &  ckpt.resolve_mispred & w_tag_vld;
    assign w_cor     = ckpt.resolve_valid & ~ckpt.resolve_mispred & w_tag_vld;
    assign w_alloc   = ckpt.alloc_req & w_alloc_ok & ~(ckpt.resolve_valid & ckpt.resolve_mispred);
    // Age of the mispredicted branch measured from head; everything at or beyond it is squashed.
    assign w_off_t   = ckpt.resolve_tag - w_head_idx;
    assign w_retire  = (r_head != r_tail) &
                       (~w_vld[w_head_idx] | (w_cor & (ckpt.resolve_tag == w_head_idx)));

    for (genvar i = 0; i < NUM_CKPT; i++) begin : g_slot
        localparam ckpt_tag_t IDX = ckpt_tag_t'(i);
        ckpt_tag_t w_off_i;
        assign w_off_i  = IDX - w_head_idx;
        assign w_clr[i] = (w_cor & (ckpt.resolve_tag == IDX)) | (w_mis & (w_off_i >= w_off_t));

        busy_ckpt_slot u_slot (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (w_alloc & (w_tail_idx == IDX)),
            .i_wdata (ckpt.live_busy & ~w_dmask),
            .i_clr   (w_clr[i]),
            .i_dmask (w_dmask),
            .o_snap  (w_snap[i]),
            .o_vld   (w_vld[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_recall <= 1'b0;
            r_rsnap  <= '0;
        end else begin
            if (w_retire) r_head <= r_head + 1'b1;
            if (w_mis)        r_tail <= r_head + ckpt_ptr_t'(w_off_t);
            else if (w_alloc) r_tail <= r_tail + 1'b1;
            r_recall <= w_mis;
            r_rsnap  <= w_mis ? (w_snap[ckpt.resolve_tag] & ~w_dmask) : '0;
        end
    end

    assign ckpt.alloc_ok      = w_alloc_ok;
    assign ckpt.alloc_tag     = w_tail_idx;
    assign ckpt.ckpt_count    = w_count;
    assign ckpt.if_recall     = r_recall;
    // busy_bit_table's recall write wins over same-cycle done, so this cycle's writebacks are masked here.
    assign ckpt.recalled_list = r_recall ? (r_rsnap & ~w_dmask) : '0;
endmodule
